tag_tx_ctrl: RTL and testbench
==============================

Name: tag_tx_ctrl

Overview:
- Anchor-side transmit controller; the peer of the tag receive controller.
- Raises the GPIO sync trigger toward the tag and waits for the tag's rx-valid acknowledge.
- Emits a two-level BPSK-style sync preamble (+A, then -A) on IQ, then steps an NCO phase word through NSYMB frequency-hopped symbols for an external DDS.
- Sits between the GPIO controller (gpio_in/gpio_out register view) and the TX DDS/DAC path.

Parameters:
DATA_WIDTH, 16, IQ sample width
PHASE_WIDTH, 24, NCO phase/increment width
NSYMB_WIDTH, 16, symbol counter width
GPIO_REG_WIDTH, 12, GPIO register width
NSYMB, 64, symbols per burst
NSIG, 326780, samples per symbol
DPH_INC, 131072, phase-increment step between symbols
START_PH_INC, 0, phase increment of symbol 0
SYNC_SIG_N, 8000, samples per preamble half
SYNC_AMP, 16384, preamble I amplitude (two's complement)
ACK_TIMEOUT, 1000000, cycles to wait for acknowledge

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous reset, active low
start  in  1  burst request pulse
abort  in  1  synchronous abort
gpio_in  in  GPIO_REG_WIDTH  GPIO input register; bit0 = tag sync_ready, bit4 = tag rx_valid
gpio_out  out  GPIO_REG_WIDTH  GPIO output register; bit2 = sync trigger, all other bits 0
tx_valid  out  1  IQ/phase outputs valid
itx_out  out  DATA_WIDTH  preamble I sample
qtx_out  out  DATA_WIDTH  preamble Q sample (always 0)
ph_inc  out  PHASE_WIDTH  current NCO increment
ph  out  PHASE_WIDTH  NCO phase accumulator
symbN  out  NSYMB_WIDTH  current symbol index
pre_sel  out  1  1 = preamble IQ active, 0 = DDS path
tx_state  out  3  FSM state (debug)
done  out  1  one-cycle pulse, burst completed
ack_err  out  1  one-cycle pulse, acknowledge timeout

Behaviour:
Reset and idle values:
- reset_n=0 at a clock edge forces all of the following, regardless of state (mid-burst included): state IDLE, gpio_out=0, tx_valid=0, itx_out=qtx_out=0, ph=0, ph_inc=START_PH_INC, symbN=0, pre_sel=0, done=0, ack_err=0.

States and encodings: IDLE=0, TRIG=1, PRE_POS=2, PRE_NEG=3, SYMB=4, DRAIN=5.

- IDLE:
  - Exits on start=1 & gpio_in[4]=0 -> TRIG.
  - start while gpio_in[4]=1 is ignored, because the tag is still busy.
- TRIG:
  - gpio_out[2]=1 from the cycle after start; timeout counter runs.
  - gpio_in[4]=1 -> PRE_POS and drop gpio_out[2] the same edge.
  - Counter reaching ACK_TIMEOUT -> IDLE with ack_err=1 for one cycle.
  - gpio_in is already synchronised by the GPIO controller; no extra synchroniser here.
- PRE_POS:
  - Duration: exactly SYNC_SIG_N cycles.
  - Outputs: tx_valid=1, pre_sel=1, itx_out=+SYNC_AMP, qtx_out=0.
- PRE_NEG:
  - Duration: exactly SYNC_SIG_N cycles.
  - Outputs: itx_out=-SYNC_AMP (two's complement), qtx_out=0.
- SYMB:
  - Outputs: pre_sel=0, itx_out=qtx_out=0, tx_valid=1.
  - Every cycle: ph <= ph + ph_inc, modulo 2^PHASE_WIDTH.
  - Each symbol lasts NSIG cycles. At a symbol boundary: symbN+1, ph_inc <= ph_inc + DPH_INC (wraps modulo 2^PHASE_WIDTH), ph not reset (phase-continuous).
  - After symbol NSYMB-1 completes -> DRAIN.
  - On SYMB entry: ph=0, ph_inc=START_PH_INC, symbN=0.
- DRAIN:
  - tx_valid=0; waits for gpio_in[4]=0, then -> IDLE with done=1 for one cycle.
  - A sync_ready (gpio_in[0]) seen in DRAIN is informational only.

Abort:
- abort=1 in any state -> IDLE next edge, same output values as reset except ph/ph_inc/symbN, which hold. No done pulse.
- abort wins over start and over every transition on the same cycle.

Counters:
- Sample counter width is ceil(log2(max(NSIG, SYNC_SIG_N, ACK_TIMEOUT)+1)).
- Counter reloads on every state entry. Terminal count = N-1, so durations are exact.

Latencies:
- start -> gpio_out[2]=1: 1 cycle.
- ack edge -> first preamble sample: 1 cycle.
- Total burst with tx_valid=1: 2*SYNC_SIG_N + NSYMB*NSIG cycles.

Test Plan:
- Params SYNC_SIG_N=4, NSIG=3, NSYMB=2, DPH_INC=16, START_PH_INC=8. Pulse start; raise gpio_in[4] 5 cycles later -> gpio_out=0x004 for 5 cycles; itx_out=16384 for 4 cycles, then -16384 (0xC000) for 4 cycles; SYMB ph_inc 8,8,8,24,24,24; ph 0,8,16,24,48,72; symbN 0,0,0,1,1,1; total tx_valid 14 cycles.
- Drop gpio_in[4] 3 cycles after DRAIN entry -> done pulses exactly once, in the cycle that state returns to IDLE; gpio_out=0.
- ACK_TIMEOUT=10, gpio_in[4] held 0 -> ack_err pulses once 10 cycles after TRIG entry; state IDLE; tx_valid never asserted.
- DPH_INC=0x800000, START_PH_INC=0x800000, NSYMB=3 -> ph_inc sequence 0x800000, 0x000000, 0x800000 (wrap); ph wraps modulo 2^24 without error.
- abort during PRE_NEG, then reset_n=0 during SYMB -> both return to IDLE next edge with tx_valid=0 and gpio_out=0; start with abort asserted in the same cycle is ignored.
- start while gpio_in[4]=1 -> stays IDLE. start pulses during SYMB -> no effect on symbN/ph sequence.

Source files
------------

// File: rtl/tag_tx_ctrl.sv
// Anchor-side burst transmitter: GPIO sync handshake with the tag, a +A/-A
// BPSK preamble on IQ, then a phase-continuous frequency-hopped NCO sweep.

module tag_tx_ctrl #(
   parameter int DATA_WIDTH     = 16,
   parameter int PHASE_WIDTH    = 24,
   parameter int NSYMB_WIDTH    = 16,
   parameter int GPIO_REG_WIDTH = 12,
   parameter int NSYMB          = 64,
   parameter int NSIG           = 326780,
   parameter int DPH_INC        = 131072,
   parameter int START_PH_INC   = 0,
   parameter int SYNC_SIG_N     = 8000,
   parameter int SYNC_AMP       = 16384,
   parameter int ACK_TIMEOUT    = 1000000
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      start,
   input  logic                      abort,
   input  logic [GPIO_REG_WIDTH-1:0] gpio_in,
   output logic [GPIO_REG_WIDTH-1:0] gpio_out,
   output logic                      tx_valid,
   output logic [DATA_WIDTH-1:0]     itx_out,
   output logic [DATA_WIDTH-1:0]     qtx_out,
   output logic [PHASE_WIDTH-1:0]    ph_inc,
   output logic [PHASE_WIDTH-1:0]    ph,
   output logic [NSYMB_WIDTH-1:0]    symbN,
   output logic                      pre_sel,
   output logic [2:0]                tx_state,
   output logic                      done,
   output logic                      ack_err
);

   localparam int MAX_A   = (NSIG > SYNC_SIG_N) ? NSIG : SYNC_SIG_N;
   localparam int CNT_MAX = (MAX_A > ACK_TIMEOUT) ? MAX_A : ACK_TIMEOUT;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0]       ACK_LAST  = CNT_W'(ACK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0]       SYNC_LAST = CNT_W'(SYNC_SIG_N - 1);
   localparam logic [CNT_W-1:0]       SIG_LAST  = CNT_W'(NSIG - 1);
   localparam logic [NSYMB_WIDTH-1:0] SYMB_LAST = NSYMB_WIDTH'(NSYMB - 1);
   localparam logic [PHASE_WIDTH-1:0] START_INC = PHASE_WIDTH'(START_PH_INC);
   localparam logic [PHASE_WIDTH-1:0] STEP_INC  = PHASE_WIDTH'(DPH_INC);
   localparam logic [DATA_WIDTH-1:0]  AMP_POS   = DATA_WIDTH'(SYNC_AMP);
   localparam logic [DATA_WIDTH-1:0]  AMP_NEG   = DATA_WIDTH'(-SYNC_AMP);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_TRIG    = 3'd1,
      ST_PRE_POS = 3'd2,
      ST_PRE_NEG = 3'd3,
      ST_SYMB    = 3'd4,
      ST_DRAIN   = 3'd5
   } state_t;

   state_t                    state_q, state_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic [GPIO_REG_WIDTH-1:0] gpio_out_q, gpio_out_d;
   logic                      tx_valid_q, tx_valid_d;
   logic [DATA_WIDTH-1:0]     itx_q, itx_d;
   logic [PHASE_WIDTH-1:0]    ph_q, ph_d;
   logic [PHASE_WIDTH-1:0]    ph_inc_q, ph_inc_d;
   logic [NSYMB_WIDTH-1:0]    symb_q, symb_d;
   logic                      pre_sel_q, pre_sel_d;
   logic                      done_q, done_d;
   logic                      ack_err_q, ack_err_d;

   logic rx_valid;
   logic gpio_unused;

   // gpio_in is already synchronised upstream; only the tag rx_valid bit steers the FSM.
   assign rx_valid    = gpio_in[4];
   assign gpio_unused = ^{gpio_in[GPIO_REG_WIDTH-1:5], gpio_in[3:0]};

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      ph_d      = ph_q;
      ph_inc_d  = ph_inc_q;
      symb_d    = symb_q;
      done_d    = 1'b0;
      ack_err_d = 1'b0;

      if (abort) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start && !rx_valid) begin
                  state_d = ST_TRIG;
                  cnt_d   = '0;
               end
            end
            ST_TRIG: begin
               // A late acknowledge on the timeout cycle still starts the burst.
               if (rx_valid) begin
                  state_d = ST_PRE_POS;
                  cnt_d   = '0;
               end else if (cnt_q == ACK_LAST) begin
                  state_d   = ST_IDLE;
                  cnt_d     = '0;
                  ack_err_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            ST_PRE_POS: begin
               if (cnt_q == SYNC_LAST) begin
                  state_d = ST_PRE_NEG;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            ST_PRE_NEG: begin
               if (cnt_q == SYNC_LAST) begin
                  state_d  = ST_SYMB;
                  cnt_d    = '0;
                  ph_d     = '0;
                  ph_inc_d = START_INC;
                  symb_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            ST_SYMB: begin
               if (cnt_q == SIG_LAST) begin
                  cnt_d = '0;
                  if (symb_q == SYMB_LAST) begin
                     state_d = ST_DRAIN;
                  end else begin
                     // Hop frequency but keep accumulating phase across the boundary.
                     symb_d   = symb_q + NSYMB_WIDTH'(1);
                     ph_inc_d = ph_inc_q + STEP_INC;
                     ph_d     = ph_q + ph_inc_q;
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
                  ph_d  = ph_q + ph_inc_q;
               end
            end
            ST_DRAIN: begin
               if (!rx_valid) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         endcase
      end

      // Outputs are decoded from the next state so they are registered alongside it.
      gpio_out_d    = '0;
      gpio_out_d[2] = (state_d == ST_TRIG);
      tx_valid_d    = (state_d == ST_PRE_POS) || (state_d == ST_PRE_NEG) || (state_d == ST_SYMB);
      pre_sel_d     = (state_d == ST_PRE_POS) || (state_d == ST_PRE_NEG);
      itx_d         = '0;
      if (state_d == ST_PRE_POS) begin
         itx_d = AMP_POS;
      end else if (state_d == ST_PRE_NEG) begin
         itx_d = AMP_NEG;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         gpio_out_q <= '0;
         tx_valid_q <= 1'b0;
         itx_q      <= '0;
         ph_q       <= '0;
         ph_inc_q   <= START_INC;
         symb_q     <= '0;
         pre_sel_q  <= 1'b0;
         done_q     <= 1'b0;
         ack_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         gpio_out_q <= gpio_out_d;
         tx_valid_q <= tx_valid_d;
         itx_q      <= itx_d;
         ph_q       <= ph_d;
         ph_inc_q   <= ph_inc_d;
         symb_q     <= symb_d;
         pre_sel_q  <= pre_sel_d;
         done_q     <= done_d;
         ack_err_q  <= ack_err_d;
      end
   end

   assign gpio_out = gpio_out_q;
   assign tx_valid = tx_valid_q;
   assign itx_out  = itx_q;
   assign qtx_out  = '0;
   assign ph_inc   = ph_inc_q;
   assign ph       = ph_q;
   assign symbN    = symb_q;
   assign pre_sel  = pre_sel_q;
   assign tx_state = state_q;
   assign done     = done_q;
   assign ack_err  = ack_err_q;

endmodule

// File: tb/tb_tag_tx_ctrl.sv
// Bench for tag_tx_ctrl: two instances (plain hop plan and a wrapping hop plan)
// share stimulus; expected bursts come from closed-form phase arithmetic.

module tb_tag_tx_ctrl;

   localparam int SYNC_N  = 4;
   localparam int NSIG_T  = 3;
   localparam int ACK_TO  = 10;
   localparam int COLLECT = 2 * SYNC_N + 3 * NSIG_T + 2;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic        abort;
   logic [11:0] gpio_in;

   logic [11:0] gpio_out [2];
   logic        tx_valid [2];
   logic [15:0] itx_out  [2];
   logic [15:0] qtx_out  [2];
   logic [23:0] ph_inc   [2];
   logic [23:0] ph       [2];
   logic [15:0] symbN    [2];
   logic        pre_sel  [2];
   logic [2:0]  tx_state [2];
   logic        done     [2];
   logic        ack_err  [2];

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   tag_tx_ctrl #(
      .NSYMB(2), .NSIG(NSIG_T), .DPH_INC(16), .START_PH_INC(8),
      .SYNC_SIG_N(SYNC_N), .ACK_TIMEOUT(ACK_TO)
   ) dut_m (
      .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .gpio_in(gpio_in),
      .gpio_out(gpio_out[0]), .tx_valid(tx_valid[0]), .itx_out(itx_out[0]),
      .qtx_out(qtx_out[0]), .ph_inc(ph_inc[0]), .ph(ph[0]), .symbN(symbN[0]),
      .pre_sel(pre_sel[0]), .tx_state(tx_state[0]), .done(done[0]), .ack_err(ack_err[0])
   );

   tag_tx_ctrl #(
      .NSYMB(3), .NSIG(NSIG_T), .DPH_INC('h800000), .START_PH_INC('h800000),
      .SYNC_SIG_N(SYNC_N), .ACK_TIMEOUT(ACK_TO)
   ) dut_w (
      .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .gpio_in(gpio_in),
      .gpio_out(gpio_out[1]), .tx_valid(tx_valid[1]), .itx_out(itx_out[1]),
      .qtx_out(qtx_out[1]), .ph_inc(ph_inc[1]), .ph(ph[1]), .symbN(symbN[1]),
      .pre_sel(pre_sel[1]), .tx_state(tx_state[1]), .done(done[1]), .ack_err(ack_err[1])
   );

   // ---------------- reference model ----------------
   function automatic int p_nsymb(int d);
      return (d == 0) ? 2 : 3;
   endfunction

   function automatic longint p_start(int d);
      return (d == 0) ? 64'd8 : 64'h800000;
   endfunction

   function automatic longint p_dph(int d);
      return (d == 0) ? 64'd16 : 64'h800000;
   endfunction

   function automatic int p_total(int d);
      return 2 * SYNC_N + p_nsymb(d) * NSIG_T;
   endfunction

   function automatic logic [23:0] inc_of(int d, int s);
      longint v;
      v = p_start(d) + longint'(s) * p_dph(d);
      return v[23:0];
   endfunction

   // Phase after k SYMB cycles: full symbols at their own increments, plus the partial one.
   function automatic logic [23:0] ph_of(int d, int k);
      longint acc;
      int s;
      int j;
      s   = k / NSIG_T;
      j   = k % NSIG_T;
      acc = 0;
      for (int i = 0; i < s; i++) acc += longint'(NSIG_T) * longint'(inc_of(d, i));
      acc += longint'(j) * longint'(inc_of(d, s));
      return acc[23:0];
   endfunction

   task automatic exp_sample(input int d, input int k, output logic [96:0] e, output logic [96:0] m);
      int kk;
      m = {33'h1_FFFF_FFFF, 64'h0};
      if (k < SYNC_N) begin
         e = {1'b1, 16'h4000, 16'h0000, 64'h0};
      end else if (k < 2 * SYNC_N) begin
         e = {1'b1, 16'hC000, 16'h0000, 64'h0};
      end else begin
         kk = k - 2 * SYNC_N;
         e  = {1'b0, 16'h0, 16'h0, inc_of(d, kk / NSIG_T), ph_of(d, kk), 16'(kk / NSIG_T)};
         m  = '1;
      end
   endtask

   function automatic logic [96:0] act_vec(int d);
      return {pre_sel[d], itx_out[d], qtx_out[d], ph_inc[d], ph[d], symbN[d]};
   endfunction

   task automatic set_gpio(input bit rx);
      logic [11:0] r;
      r     = 12'($urandom);
      r[4]  = rx;
      gpio_in = r;
   endtask

   // Call at a negedge in IDLE; returns at the negedge where the ack is driven.
   task automatic begin_burst(input int ack_dly);
      start = 1'b1;
      for (int i = 0; i < ack_dly; i++) begin
         @(negedge clk);
         start = 1'b0;
         for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (gpio_out[d] !== 12'h004 || tx_state[d] !== 3'd1)
               $display("FAIL trig dut%0d cyc%0d: gpio_out=%h state=%0d want 004/1", d, i, gpio_out[d], tx_state[d]);
            else n_pass++;
         end
      end
      set_gpio(1'b1);
   endtask

   task automatic run_burst(input int ack_dly, input int drain_dly, input bit glitch);
      int idx [2];
      logic [96:0] e, m, a;
      $display("burst ack_dly=%0d drain_dly=%0d glitch=%0d", ack_dly, drain_dly, glitch);
      begin_burst(ack_dly);
      idx = '{0, 0};
      for (int c = 0; c < COLLECT; c++) begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            if (c == 0) begin
               n_checks++;
               if (tx_valid[d] !== 1'b1 || gpio_out[d] !== 12'h000)
                  $display("FAIL first_sample dut%0d: tx_valid=%b gpio_out=%h want 1/000", d, tx_valid[d], gpio_out[d]);
               else n_pass++;
            end
            if (tx_valid[d] === 1'b1) begin
               n_checks++;
               if (idx[d] >= p_total(d)) begin
                  $display("FAIL overrun dut%0d: tx_valid still 1 at sample %0d, want %0d samples", d, idx[d], p_total(d));
               end else begin
                  exp_sample(d, idx[d], e, m);
                  a = act_vec(d) & m;
                  if (a !== e) $display("FAIL sample dut%0d idx%0d: got %h want %h", d, idx[d], a, e);
                  else n_pass++;
               end
               idx[d]++;
            end
         end
         start = (glitch && c >= 9 && c <= 12) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      start = 1'b0;
      for (int d = 0; d < 2; d++) begin
         n_checks++;
         if (idx[d] !== p_total(d) || tx_state[d] !== 3'd5)
            $display("FAIL tx_len dut%0d: samples=%0d state=%0d want %0d/5", d, idx[d], tx_state[d], p_total(d));
         else n_pass++;
      end
      for (int i = 0; i < drain_dly; i++) begin
         set_gpio(1'b1);
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (done[d] !== 1'b0 || tx_state[d] !== 3'd5)
               $display("FAIL drain_wait dut%0d: done=%b state=%0d want 0/5", d, done[d], tx_state[d]);
            else n_pass++;
         end
      end
      set_gpio(1'b0);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         n_checks++;
         if (done[d] !== 1'b1 || tx_state[d] !== 3'd0 || gpio_out[d] !== 12'h000 || tx_valid[d] !== 1'b0)
            $display("FAIL done_pulse dut%0d: done=%b state=%0d gpio_out=%h want 1/0/000", d, done[d], tx_state[d], gpio_out[d]);
         else n_pass++;
      end
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         n_checks++;
         if (done[d] !== 1'b0 || tx_state[d] !== 3'd0)
            $display("FAIL done_once dut%0d: done=%b state=%0d want 0/0", d, done[d], tx_state[d]);
         else n_pass++;
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      logic [114:0] got, want;
      reset_n = 1'b0;
      start   = 1'b0;
      abort   = 1'b0;
      set_gpio(1'b0);
      repeat (3) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         got  = {gpio_out[d], tx_valid[d], itx_out[d], qtx_out[d], ph[d], ph_inc[d], symbN[d],
                 pre_sel[d], tx_state[d], done[d], ack_err[d]};
         want = {12'h0, 1'b0, 16'h0, 16'h0, 24'h0, 24'(p_start(d)), 16'h0, 1'b0, 3'd0, 1'b0, 1'b0};
         n_checks++;
         if (got !== want) $display("FAIL reset dut%0d: got %h want %h", d, got, want);
         else n_pass++;
      end
      reset_n = 1'b1;
      @(negedge clk);
      $display("reset done");
   endtask

   task automatic test_idle_busy();
      set_gpio(1'b1);
      start = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         start = 1'b0;
         for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (tx_state[d] !== 3'd0 || gpio_out[d] !== 12'h000)
               $display("FAIL busy_start dut%0d: state=%0d gpio_out=%h want 0/000", d, tx_state[d], gpio_out[d]);
            else n_pass++;
         end
      end
      set_gpio(1'b0);
      @(negedge clk);
      $display("start while tag busy");
   endtask

   task automatic test_timeout();
      start = 1'b1;
      for (int i = 0; i <= 12; i++) begin
         @(negedge clk);
         start = 1'b0;
         for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (ack_err[d] !== (i == ACK_TO) || tx_state[d] !== ((i < ACK_TO) ? 3'd1 : 3'd0) ||
                tx_valid[d] !== 1'b0 || gpio_out[d] !== ((i < ACK_TO) ? 12'h004 : 12'h000))
               $display("FAIL timeout dut%0d cyc%0d: ack_err=%b state=%0d tx_valid=%b gpio_out=%h want %b/%0d/0/%h",
                        d, i, ack_err[d], tx_state[d], tx_valid[d], gpio_out[d],
                        (i == ACK_TO), (i < ACK_TO) ? 1 : 0, (i < ACK_TO) ? 12'h004 : 12'h000);
            else n_pass++;
         end
      end
      $display("ack timeout");
   endtask

   task automatic test_abort();
      logic [96:0] e, m;
      // abort in PRE_NEG, then start+abort together from IDLE
      begin_burst(2);
      for (int c = 0; c <= 5; c++) @(negedge clk);
      abort = 1'b1;
      start = 1'b1;
      set_gpio(1'b0);
      for (int r = 0; r < 2; r++) begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (tx_state[d] !== 3'd0 || tx_valid[d] !== 1'b0 || gpio_out[d] !== 12'h000 ||
                pre_sel[d] !== 1'b0 || itx_out[d] !== 16'h0 || done[d] !== 1'b0)
               $display("FAIL abort_pre dut%0d r%0d: state=%0d tx_valid=%b gpio_out=%h pre_sel=%b itx=%h done=%b want idle",
                        d, r, tx_state[d], tx_valid[d], gpio_out[d], pre_sel[d], itx_out[d], done[d]);
            else n_pass++;
         end
      end
      abort = 1'b0;
      start = 1'b0;
      @(negedge clk);
      $display("abort in preamble");
      // abort in SYMB: phase state holds the value shown at the abort cycle
      begin_burst(3);
      for (int c = 0; c <= 10; c++) @(negedge clk);
      abort = 1'b1;
      set_gpio(1'b0);
      @(negedge clk);
      abort = 1'b0;
      for (int d = 0; d < 2; d++) begin
         exp_sample(d, 10, e, m);
         n_checks++;
         if (tx_state[d] !== 3'd0 || tx_valid[d] !== 1'b0 || {ph_inc[d], ph[d], symbN[d]} !== e[63:0])
            $display("FAIL abort_hold dut%0d: state=%0d tx_valid=%b phase=%h want 0/0/%h",
                     d, tx_state[d], tx_valid[d], {ph_inc[d], ph[d], symbN[d]}, e[63:0]);
         else n_pass++;
      end
      @(negedge clk);
      $display("abort in symbols");
      // reset in SYMB
      begin_burst(1);
      for (int c = 0; c <= 11; c++) @(negedge clk);
      reset_n = 1'b0;
      set_gpio(1'b0);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         n_checks++;
         if (tx_state[d] !== 3'd0 || tx_valid[d] !== 1'b0 || gpio_out[d] !== 12'h000 ||
             ph[d] !== 24'h0 || ph_inc[d] !== 24'(p_start(d)) || symbN[d] !== 16'h0)
            $display("FAIL reset_symb dut%0d: state=%0d tx_valid=%b gpio_out=%h ph=%h ph_inc=%h symbN=%0d want reset values",
                     d, tx_state[d], tx_valid[d], gpio_out[d], ph[d], ph_inc[d], symbN[d]);
         else n_pass++;
      end
      reset_n = 1'b1;
      @(negedge clk);
      $display("reset in symbols");
   endtask

   task automatic test_main_burst();
      run_burst(5, 3, 1'b0);
   endtask

   task automatic test_back_to_back();
      for (int n = 0; n < 6; n++) run_burst($urandom_range(1, 6), $urandom_range(0, 4), 1'b1);
   endtask

   initial begin
      test_reset();
      test_idle_busy();
      test_main_burst();
      test_timeout();
      test_abort();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
